// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared depth codes, timing config struct and colour expansion helpers
// Contents: DEPTH_* log2(bpp) codes, axis_cfg_t/timing_cfg_t timing records,
//           unpack16 (RGB565 -> RGB888) and unpack8 (RGB332 -> RGB888).
package video_pkg;

  localparam logic [2:0] DEPTH_1BPP  = 3'd0;
  localparam logic [2:0] DEPTH_2BPP  = 3'd1;
  localparam logic [2:0] DEPTH_4BPP  = 3'd2;
  localparam logic [2:0] DEPTH_8BPP  = 3'd3;
  localparam logic [2:0] DEPTH_16BPP = 3'd4;
  localparam logic [2:0] DEPTH_32BPP = 3'd5;

  // Fields are kept at 32 bits so the struct is independent of CNT_WIDTH;
  // the top zero-extends its counter-width inputs into it.
  typedef struct packed {
    logic [31:0] total;
    logic [31:0] end_disp;
    logic [31:0] srt_sync;
    logic [31:0] end_sync;
  } axis_cfg_t;

  typedef struct packed {
    axis_cfg_t h;
    axis_cfg_t v;
  } timing_cfg_t;

  // RGB565: each channel widened by replicating its MSBs into the low bits.
  function automatic logic [23:0] unpack16(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  // RGB332: r/g = {3b,3b,top 2b}, b = 2b repeated four times.
  function automatic logic [23:0] unpack8(input logic [7:0] p);
    return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
  endfunction

endpackage

// File: rtl/video_timing.sv
// rtl/video_timing.sv - CRT horizontal/vertical counters, raw syncs, active area and frame irq
// Ports: clk, rst_n (async active-low), enable, cfg (timing_cfg_t);
//        hc, vc counters; hsync_raw/vsync_raw (1 = inside sync window);
//        active, frame_irq, line_end (last hc of a line), frame_end (last position of a frame).
module video_timing
  import video_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  timing_cfg_t          cfg,
  output logic [CNT_WIDTH-1:0] hc,
  output logic [CNT_WIDTH-1:0] vc,
  output logic                 hsync_raw,
  output logic                 vsync_raw,
  output logic                 active,
  output logic                 frame_irq,
  output logic                 line_end,
  output logic                 frame_end
);

  logic [31:0] hc_x;
  logic [31:0] vc_x;

  assign hc_x = 32'(hc);
  assign vc_x = 32'(vc);

  // ">=" rather than "==" so a bad total (0, or below the current count) still wraps.
  assign line_end  = enable && (hc_x + 32'd1 >= cfg.h.total);
  assign frame_end = line_end && (vc_x + 32'd1 >= cfg.v.total);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc <= '0;
      vc <= '0;
    end else if (!enable) begin
      hc <= '0;
      vc <= '0;
    end else if (line_end) begin
      hc <= '0;
      vc <= frame_end ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  assign active    = enable && (hc_x < cfg.h.end_disp) && (vc_x < cfg.v.end_disp);
  assign hsync_raw = enable && (hc_x >= cfg.h.srt_sync) && (hc_x < cfg.h.end_sync);
  assign vsync_raw = enable && (vc_x >= cfg.v.srt_sync) && (vc_x < cfg.v.end_sync);
  assign frame_irq = enable && (hc == '0) && (vc_x == cfg.v.end_disp);

endmodule

// File: rtl/video_scanout.sv
// rtl/video_scanout.sv - VGA scanout: shadowed scan params, line pointer, fetch, pixel unpack
// Ports: clk, rst_n; cfg_* scan setup from the CSR block; mem_en/mem_addr/mem_rdata
//        fixed-latency framebuffer read port; red/green/blue, hsync, vsync, de, frame_irq.
module video_scanout
  import video_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_enable,
  input  logic [CNT_WIDTH-1:0]  cfg_h_total,
  input  logic [CNT_WIDTH-1:0]  cfg_h_end_disp,
  input  logic [CNT_WIDTH-1:0]  cfg_h_srt_sync,
  input  logic [CNT_WIDTH-1:0]  cfg_h_end_sync,
  input  logic [CNT_WIDTH-1:0]  cfg_v_total,
  input  logic [CNT_WIDTH-1:0]  cfg_v_end_disp,
  input  logic [CNT_WIDTH-1:0]  cfg_v_srt_sync,
  input  logic [CNT_WIDTH-1:0]  cfg_v_end_sync,
  input  logic                  cfg_hsync_pol,
  input  logic                  cfg_vsync_pol,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic [2:0]            cfg_depth,
  input  logic [1:0]            cfg_hscale,
  input  logic [1:0]            cfg_vscale,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic                  frame_irq
);

  localparam int IW = $clog2(DATA_WIDTH);

  function automatic logic [2:0] clamp_depth(input logic [2:0] d);
    return (d > 3'(IW)) ? 3'(IW) : d;
  endfunction

  function automatic logic [1:0] clamp_scale(input logic [1:0] s);
    return (s == 2'd3) ? 2'd2 : s;
  endfunction

  timing_cfg_t          tcfg;
  logic [CNT_WIDTH-1:0] hc, vc;
  logic                 hs_raw, vs_raw, active, line_end, frame_end;

  assign tcfg.h.total    = 32'(cfg_h_total);
  assign tcfg.h.end_disp = 32'(cfg_h_end_disp);
  assign tcfg.h.srt_sync = 32'(cfg_h_srt_sync);
  assign tcfg.h.end_sync = 32'(cfg_h_end_sync);
  assign tcfg.v.total    = 32'(cfg_v_total);
  assign tcfg.v.end_disp = 32'(cfg_v_end_disp);
  assign tcfg.v.srt_sync = 32'(cfg_v_srt_sync);
  assign tcfg.v.end_sync = 32'(cfg_v_end_sync);

  video_timing #(.CNT_WIDTH(CNT_WIDTH)) u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (cfg_enable),
    .cfg       (tcfg),
    .hc        (hc),
    .vc        (vc),
    .hsync_raw (hs_raw),
    .vsync_raw (vs_raw),
    .active    (active),
    .frame_irq (frame_irq),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // Shadowed scan parameters and line pointer.
  logic                  en_q, first_cyc, load;
  logic [ADDR_WIDTH-1:0] stride_s, lineptr;
  logic [2:0]            depth_s;
  logic [1:0]            hscale_s, vscale_s;
  logic [CNT_WIDTH-1:0]  vmask, vc_next;
  logic                  stride_add;

  assign first_cyc  = cfg_enable && !en_q;
  assign load       = first_cyc || frame_end;
  assign vc_next    = vc + 1'b1;
  assign vmask      = CNT_WIDTH'((32'd1 << vscale_s) - 32'd1);
  assign stride_add = line_end && ((vc_next & vmask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      stride_s <= '0;
      depth_s  <= '0;
      hscale_s <= '0;
      vscale_s <= '0;
      lineptr  <= '0;
    end else begin
      en_q <= cfg_enable;
      if (load) begin
        stride_s <= cfg_stride;
        depth_s  <= clamp_depth(cfg_depth);
        hscale_s <= clamp_scale(cfg_hscale);
        vscale_s <= clamp_scale(cfg_vscale);
        lineptr  <= cfg_base;   // a new frame's base overrides a coincident stride step
      end else if (stride_add) begin
        lineptr  <= lineptr + stride_s;
      end
    end
  end

  // The enable-rising cycle is already pixel (0,0), before the shadows have
  // loaded, so it addresses straight from the cfg inputs.
  logic [2:0]            depth_e;
  logic [1:0]            hscale_e;
  logic [ADDR_WIDTH-1:0] lineptr_e;

  assign depth_e   = first_cyc ? clamp_depth(cfg_depth)   : depth_s;
  assign hscale_e  = first_cyc ? clamp_scale(cfg_hscale)  : hscale_s;
  assign lineptr_e = first_cyc ? cfg_base                 : lineptr;

  // Address generation: shift = log2(pixels per word).
  logic [CNT_WIDTH-1:0]  sx, word_off;
  logic [2:0]            shift;
  logic [IW-1:0]         idx_mask, pix_idx;
  logic [ADDR_WIDTH-1:0] addr_calc, addr_hold;

  assign sx        = hc >> hscale_e;
  assign shift     = 3'(IW) - depth_e;
  assign word_off  = sx >> shift;
  assign addr_calc = lineptr_e + ADDR_WIDTH'(word_off);
  assign idx_mask  = IW'((32'd1 << shift) - 32'd1);
  assign pix_idx   = IW'(sx) & idx_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      addr_hold <= '0;
    else if (mem_en) addr_hold <= addr_calc;
  end

  assign mem_en   = active;
  assign mem_addr = mem_en ? addr_calc : addr_hold;

  // Delay line matching the read latency of the framebuffer port.
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [2:0]    depth;
    logic          de;
    logic          hs;
    logic          vs;
  } pipe_t;

  pipe_t pipe [RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{idx: pix_idx, depth: depth_e, de: active, hs: hs_raw, vs: vs_raw};
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  pipe_t         tail;
  logic [IW-1:0] shamt;
  logic [23:0]   w24, pix;

  assign tail  = pipe[RD_LATENCY-1];
  assign shamt = IW'(tail.idx << tail.depth);
  assign w24   = 24'(mem_rdata >> shamt);

  always_comb begin
    pix = '0;
    case (tail.depth)
      DEPTH_32BPP: pix = w24;
      DEPTH_16BPP: pix = unpack16(w24[15:0]);
      DEPTH_8BPP:  pix = unpack8(w24[7:0]);
      DEPTH_4BPP:  pix = {6{w24[3:0]}};
      DEPTH_2BPP:  pix = {12{w24[1:0]}};
      default:     pix = {24{w24[0]}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {red, green, blue} <= '0;
      hsync <= 1'b0;
      vsync <= 1'b0;
      de    <= 1'b0;
    end else begin
      {red, green, blue} <= tail.de ? pix : 24'h0;
      hsync <= tail.hs ^ cfg_hsync_pol;
      vsync <= tail.vs ^ cfg_vsync_pol;
      de    <= tail.de;
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
// tb/tb_video_scanout.sv - table-driven and sequence bench for video_scanout
module tb_video_scanout;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_h_total = '0, cfg_h_end_disp = '0, cfg_h_srt_sync = '0, cfg_h_end_sync = '0;
  logic [15:0] cfg_v_total = '0, cfg_v_end_disp = '0, cfg_v_srt_sync = '0, cfg_v_end_sync = '0;
  logic        cfg_hsync_pol = 1'b0, cfg_vsync_pol = 1'b0;
  logic [14:0] cfg_base = '0, cfg_stride = '0;
  logic [2:0]  cfg_depth = '0;
  logic [1:0]  cfg_hscale = '0, cfg_vscale = '0;
  logic        mem_en;
  logic [14:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, de, frame_irq;

  logic [31:0] mem [0:1023];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr[9:0]];

  video_scanout #(.ADDR_WIDTH(15), .DATA_WIDTH(32), .CNT_WIDTH(16), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(cfg_enable),
    .cfg_h_total(cfg_h_total), .cfg_h_end_disp(cfg_h_end_disp),
    .cfg_h_srt_sync(cfg_h_srt_sync), .cfg_h_end_sync(cfg_h_end_sync),
    .cfg_v_total(cfg_v_total), .cfg_v_end_disp(cfg_v_end_disp),
    .cfg_v_srt_sync(cfg_v_srt_sync), .cfg_v_end_sync(cfg_v_end_sync),
    .cfg_hsync_pol(cfg_hsync_pol), .cfg_vsync_pol(cfg_vsync_pol),
    .cfg_base(cfg_base), .cfg_stride(cfg_stride), .cfg_depth(cfg_depth),
    .cfg_hscale(cfg_hscale), .cfg_vscale(cfg_vscale),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_irq(frame_irq)
  );

  typedef struct {
    logic [2:0]  depth;
    logic [1:0]  hscale;
    logic [31:0] word;
    int          k;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fill(input logic [31:0] w);
    for (int i = 0; i < 1024; i++) mem[i] = w;
  endtask

  task automatic set_timing(input int ht, hd, hs, he, vt, vd, vs, ve);
    cfg_h_total = 16'(ht); cfg_h_end_disp = 16'(hd); cfg_h_srt_sync = 16'(hs); cfg_h_end_sync = 16'(he);
    cfg_v_total = 16'(vt); cfg_v_end_disp = 16'(vd); cfg_v_srt_sync = 16'(vs); cfg_v_end_sync = 16'(ve);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step(1);
  endtask

  task automatic start_scan();
    @(negedge clk);
    cfg_enable = 1'b1;
    cyc = 0;
    #1;
  endtask

  task automatic stop_scan();
    @(negedge clk);
    cfg_enable = 1'b0;
    step(3);
  endtask

  initial begin
    int hs_err, vs_err, de_err, irq_err, hs_cnt, vs_cnt, de_cnt, irq_cnt, addr_err, c, hm, vm;

    // depth, hscale, word, pixel hc, expected rgb
    vecs.push_back('{3'd4, 2'd0, 32'hF800_07E0,  0, 24'h00FF00});
    vecs.push_back('{3'd4, 2'd0, 32'hF800_07E0,  1, 24'hFF0000});
    vecs.push_back('{3'd4, 2'd0, 32'h0000_8410,  0, 24'h848284});
    vecs.push_back('{3'd5, 2'd0, 32'h0012_3456,  3, 24'h123456});
    vecs.push_back('{3'd7, 2'd0, 32'hAB65_4321,  0, 24'h654321});
    vecs.push_back('{3'd3, 2'd0, 32'h031C_E0FF,  0, 24'hFFFFFF});
    vecs.push_back('{3'd3, 2'd0, 32'h031C_E0FF,  1, 24'hFF0000});
    vecs.push_back('{3'd3, 2'd0, 32'h031C_E0FF,  2, 24'h00FF00});
    vecs.push_back('{3'd3, 2'd0, 32'h031C_E0FF,  3, 24'h0000FF});
    vecs.push_back('{3'd3, 2'd0, 32'h0000_0092,  0, 24'h9292AA});
    vecs.push_back('{3'd2, 2'd0, 32'h3000_00A5,  0, 24'h555555});
    vecs.push_back('{3'd2, 2'd0, 32'h3000_00A5,  1, 24'hAAAAAA});
    vecs.push_back('{3'd2, 2'd0, 32'h3000_00A5,  7, 24'h333333});
    vecs.push_back('{3'd1, 2'd0, 32'h0000_0024,  1, 24'h555555});
    vecs.push_back('{3'd1, 2'd0, 32'h0000_0024,  2, 24'hAAAAAA});
    vecs.push_back('{3'd0, 2'd0, 32'h8000_0000, 31, 24'hFFFFFF});
    vecs.push_back('{3'd0, 2'd1, 32'h0000_0001,  1, 24'hFFFFFF});
    vecs.push_back('{3'd0, 2'd1, 32'h0000_0001,  2, 24'h000000});
    vecs.push_back('{3'd0, 2'd3, 32'h0000_0002,  3, 24'h000000});
    vecs.push_back('{3'd0, 2'd3, 32'h0000_0002,  4, 24'hFFFFFF});
    vecs.push_back('{3'd0, 2'd2, 32'h0000_0002,  7, 24'hFFFFFF});

    fill(32'h0);
    repeat (3) @(negedge clk);
    #1;
    check("reset_rgb", {8'h0, red, green, blue}, 32'h0);
    check("reset_ctl", {hsync, vsync, de, mem_en, frame_irq}, 32'h0);
    check("reset_addr", 32'(mem_addr), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Timing: h 10/6/7/8, v 5/3/4/5, 50-cycle frame
    set_timing(10, 6, 7, 8, 5, 3, 4, 5);
    cfg_depth = 3'd5;
    hs_err = 0; vs_err = 0; de_err = 0; irq_err = 0;
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0; irq_cnt = 0;
    start_scan();
    for (int j = 1; j <= 100; j++) begin
      logic ehs, evs, ede, eirq;
      step(1);
      c = j - 2;
      ehs = 1'b0; evs = 1'b0; ede = 1'b0;
      if (c >= 0) begin
        hm = c % 10;
        vm = (c / 10) % 5;
        ehs = (hm == 7);
        evs = (vm == 4);
        ede = (hm < 6) && (vm < 3);
      end
      eirq = ((j % 50) == 30);
      if (hsync !== ehs) hs_err++;
      if (vsync !== evs) vs_err++;
      if (de !== ede) de_err++;
      if (frame_irq !== eirq) irq_err++;
      hs_cnt += int'(hsync);
      vs_cnt += int'(vsync);
      de_cnt += int'(de);
      irq_cnt += int'(frame_irq);
    end
    check("hsync_pattern_errs", hs_err, 0);
    check("vsync_pattern_errs", vs_err, 0);
    check("de_pattern_errs", de_err, 0);
    check("irq_pattern_errs", irq_err, 0);
    check("hsync_count", hs_cnt, 10);
    check("vsync_count", vs_cnt, 19);
    check("de_count", de_cnt, 36);
    check("irq_count", irq_cnt, 2);
    stop_scan();

    // Unpack table on a 80x4 raster, base 0
    set_timing(80, 64, 70, 72, 4, 2, 3, 4);
    foreach (vecs[i]) begin
      cfg_depth = vecs[i].depth;
      cfg_hscale = vecs[i].hscale;
      cfg_vscale = 2'd0;
      cfg_base = '0;
      cfg_stride = '0;
      fill(vecs[i].word);
      start_scan();
      step(vecs[i].k + 2);
      check($sformatf("vec%0d_rgb", i), {8'h0, red, green, blue}, {8'h0, vecs[i].rgb});
      check($sformatf("vec%0d_de", i), 32'(de), 32'h1);
      stop_scan();
    end

    // 16 bpp from base 0x100
    fill(32'h0);
    mem[10'h100] = 32'hF800_07E0;
    cfg_depth = 3'd4; cfg_hscale = 2'd0; cfg_base = 15'h100;
    start_scan();
    check("rgb565_addr_p0", 32'(mem_addr), 32'h100);
    step(1);
    check("rgb565_addr_p1", 32'(mem_addr), 32'h100);
    step(1);
    check("rgb565_addr_p2", 32'(mem_addr), 32'h101);
    check("rgb565_rgb_p0", {8'h0, red, green, blue}, 32'h00FF00);
    step(1);
    check("rgb565_rgb_p1", {8'h0, red, green, blue}, 32'hFF0000);
    stop_scan();

    // 1 bpp, hscale 1: one word covers all 64 displayed pixels
    fill(32'h0);
    mem[10'h200] = 32'h1;
    cfg_depth = 3'd0; cfg_hscale = 2'd1; cfg_base = 15'h200;
    addr_err = 0;
    start_scan();
    for (int j = 0; j <= 64; j++) begin
      if (j > 0) step(1);
      if (j < 64 && (mem_addr !== 15'h200 || mem_en !== 1'b1)) addr_err++;
      if (j == 2) check("bpp1_rgb_p0", {8'h0, red, green, blue}, 32'hFFFFFF);
      if (j == 3) check("bpp1_rgb_p1", {8'h0, red, green, blue}, 32'hFFFFFF);
      if (j == 4) check("bpp1_rgb_p2", {8'h0, red, green, blue}, 32'h000000);
    end
    check("bpp1_addr_errs", addr_err, 0);
    check("bpp1_mem_en_blank", 32'(mem_en), 32'h0);
    stop_scan();

    // vscale 1, stride 4: line starts 0,0,4,4,8
    set_timing(10, 6, 7, 8, 6, 5, 5, 6);
    cfg_depth = 3'd5; cfg_hscale = 2'd0; cfg_vscale = 2'd1; cfg_base = '0; cfg_stride = 15'd4;
    start_scan();
    for (int l = 0; l < 5; l++) begin
      logic [31:0] exp_a;
      exp_a = 32'((l / 2) * 4);
      step_to(10 * l);
      check($sformatf("vscale_line%0d", l), 32'(mem_addr), exp_a);
    end
    stop_scan();

    // cfg_base written mid-frame takes effect on the next frame
    set_timing(10, 6, 7, 8, 5, 3, 4, 5);
    cfg_vscale = 2'd0; cfg_stride = '0; cfg_base = '0;
    start_scan();
    step_to(12);
    cfg_base = 15'h40;
    step_to(20);
    check("base_old_frame", 32'(mem_addr), 32'h0);
    step_to(30);
    check("addr_hold_blank", {31'h0, mem_en, 16'h0} | 32'(mem_addr), 32'h5);
    step_to(50);
    check("base_new_frame", 32'(mem_addr), 32'h40);
    step(1);
    check("base_new_frame_p1", 32'(mem_addr), 32'h41);
    stop_scan();

    // Disable mid-line with active-low syncs, then async reset
    fill(32'h00FF_FFFF);
    cfg_base = '0; cfg_hsync_pol = 1'b1; cfg_vsync_pol = 1'b1;
    start_scan();
    step_to(3);
    check("dis_pre_rgb", {8'h0, red, green, blue}, 32'hFFFFFF);
    cfg_enable = 1'b0;
    step(1);
    check("dis_mem_en", 32'(mem_en), 32'h0);
    check("dis_lat_rgb", {8'h0, red, green, blue}, 32'hFFFFFF);
    step(1);
    check("dis_rgb", {8'h0, red, green, blue}, 32'h0);
    check("dis_syncs_de", {hsync, vsync, de}, 3'b110);
    rst_n = 1'b0;
    #1;
    check("rst_async_ctl", {hsync, vsync, de, mem_en, frame_irq}, 32'h0);
    check("rst_async_rgb_addr", {red, green, blue} | 24'(mem_addr), 32'h0);
    step(1);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
